// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive frame checker with show-ahead FIFO and error flags.
//            Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic        baud_clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [10:0] frame_in,
    output logic [7:0]  m_data,
    output logic        m_perr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [4:0]  fifo_count,
    output logic        framing_err,
    output logic        overrun_err,
    input  logic        clr_err,
    output logic [7:0]  err_cnt
);

    localparam int         c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] c_depth = 5'(FIFO_DEPTH);

    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [4:0]         r_count;
    logic               r_framing_err;
    logic               r_overrun_err;
    logic [7:0]         r_err_cnt;

    logic               w_fault;
    logic               w_good;
    logic               w_pop;
    logic               w_push;
    logic               w_overrun;
    logic               w_drop;
    logic               w_perr;
    logic [8:0]         w_head;

    assign w_head  = r_mem[r_rptr];
    assign m_valid = (r_count != 5'd0);
    assign m_data  = m_valid ? w_head[7:0] : 8'h00;

`ifdef UART_RX_PARITY_EN
    assign w_perr = ((^frame_in[9:1]) != (PARITY_ODD != 0));
    assign m_perr = m_valid & w_head[8];
`else
    logic w_unused;
    assign w_perr   = 1'b0;
    assign m_perr   = 1'b0;
    assign w_unused = ^{frame_in[9], w_head[8], (PARITY_ODD != 0)};
`endif

    assign w_fault   = frame_valid && (frame_in[0] || !frame_in[10]);
    assign w_good    = frame_valid && !w_fault && !rst;
    assign w_pop     = m_valid && m_ready;
    // A pop in the same cycle frees the slot the incoming frame needs.
    assign w_push    = w_good && ((r_count < c_depth) || w_pop);
    assign w_overrun = w_good && !w_push;
    assign w_drop    = w_fault || w_overrun;

    always_ff @(posedge baud_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_perr, frame_in[8:1]};
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
            r_err_cnt     <= 8'd0;
        end else begin
            if (w_fault) begin
                r_framing_err <= 1'b1;
            end else if (clr_err) begin
                r_framing_err <= 1'b0;
            end
            if (w_overrun) begin
                r_overrun_err <= 1'b1;
            end else if (clr_err) begin
                r_overrun_err <= 1'b0;
            end
            if (w_drop && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign fifo_count  = r_count;
    assign framing_err = r_framing_err;
    assign overrun_err = r_overrun_err;
    assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Self-checking bench for uart_rx_ctrl against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int PARITY_ODD = 0;

    logic        baud_clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [10:0] frame_in;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  fifo_count;
    logic        framing_err;
    logic        overrun_err;
    logic        clr_err;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [8:0] q[$];
    bit         m_fe;
    bit         m_ov;
    int         m_err;

    uart_rx_ctrl #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .baud_clk   (baud_clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame_in   (frame_in),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .clr_err    (clr_err),
        .err_cnt    (err_cnt)
    );

    always #5 baud_clk = ~baud_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p,
                                       input logic st, input logic sp);
        return {sp, p, d, st};
    endfunction

    function automatic logic [10:0] good(input logic [7:0] d);
        logic p;
        p = (^d) ^ (PARITY_ODD != 0);
        return mk(d, p, 1'b0, 1'b1);
    endfunction

    function automatic logic exp_perr(input logic [10:0] fr);
`ifdef UART_RX_PARITY_EN
        return ((^fr[9:1]) != (PARITY_ODD != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        q.delete();
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        m_err = 0;
    endfunction

    // Drive one cycle of stimulus (called just after a falling edge) and advance the model.
    task automatic step(input logic fv, input logic [10:0] fr, input logic rdy, input logic clr);
        bit pop;
        bit acc;
        bit drop;
        frame_valid = fv;
        frame_in    = fr;
        m_ready     = rdy;
        clr_err     = clr;
        pop  = (q.size() != 0) && rdy;
        acc  = 1'b0;
        drop = 1'b0;
        if (clr) begin
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
        if (fv) begin
            if (fr[0] || !fr[10]) begin
                m_fe = 1'b1;
                drop = 1'b1;
            end else if (q.size() < FIFO_DEPTH || pop) begin
                acc = 1'b1;
            end else begin
                m_ov = 1'b1;
                drop = 1'b1;
            end
        end
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({exp_perr(fr), fr[8:1]});
        if (drop && m_err < 255) m_err++;
        @(posedge baud_clk);
        @(negedge baud_clk);
        frame_valid = 1'b0;
        clr_err     = 1'b0;
        m_ready     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_valid = 1'b0; frame_in = '0; m_ready = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(negedge baud_clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", m_data); end
        checks++; if (m_perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", m_perr); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if ({framing_err, overrun_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", framing_err, overrun_err); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
        rst = 1'b0;
        @(negedge baud_clk);
    endtask

    task automatic test_basic();
        logic [10:0] f;
        f = 11'b1_0_01010101_0;
        step(1'b1, f, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 8'h55) begin failures++; $display("FAIL basic_data got=%h exp=55", m_data); end
        checks++; if (m_perr !== 1'b0) begin failures++; $display("FAIL basic_perr got=%b exp=0", m_perr); end
        step(1'b0, 11'd0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", m_valid); end
    endtask

    task automatic test_framing();
        step(1'b1, mk(8'h3C, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL framing_count got=%0d exp=0", fifo_count); end
        checks++; if (framing_err !== 1'b1) begin failures++; $display("FAIL framing_flag got=%b exp=1", framing_err); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL framing_errcnt got=%0d exp=1", err_cnt); end
        step(1'b0, 11'd0, 1'b0, 1'b1);
        checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL framing_clr got=%b exp=0", framing_err); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL framing_clr_errcnt got=%0d exp=1", err_cnt); end
        // Bad start bit together with clr_err: the set must win.
        step(1'b1, mk(8'h3C, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1);
        checks++; if (framing_err !== 1'b1) begin failures++; $display("FAIL framing_set_wins got=%b exp=1", framing_err); end
        checks++; if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL framing_errcnt2 got=%0d exp=%0d", err_cnt, m_err); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) step(1'b1, good(8'(i)), 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL overrun_count got=%0d exp=4", fifo_count); end
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun_err); end
        checks++; if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL overrun_errcnt got=%0d exp=%0d", err_cnt, m_err); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (m_data !== 8'(i) || m_valid !== 1'b1) begin failures++; $display("FAIL overrun_drain%0d got=%h/%b exp=%h/1", i, m_data, m_valid, 8'(i)); end
            step(1'b0, 11'd0, 1'b1, 1'b0);
        end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL overrun_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_full_push_pop();
        step(1'b0, 11'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, good(8'h11 + 8'(i)), 1'b0, 1'b0);
        // Head must stay stable while the consumer stalls.
        step(1'b0, 11'd0, 1'b0, 1'b0);
        checks++; if (m_data !== 8'h11) begin failures++; $display("FAIL fpp_hold got=%h exp=11", m_data); end
        step(1'b1, good(8'hA5), 1'b1, 1'b0);
        checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", fifo_count); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL fpp_no_overrun got=%b exp=0", overrun_err); end
        checks++; if (m_data !== 8'h12) begin failures++; $display("FAIL fpp_head got=%h exp=12", m_data); end
        repeat (3) step(1'b0, 11'd0, 1'b1, 1'b0);
        checks++; if (m_data !== 8'hA5 || fifo_count !== 5'd1) begin failures++; $display("FAIL fpp_tail got=%h/%0d exp=a5/1", m_data, fifo_count); end
        step(1'b1, good(8'h66), 1'b1, 1'b0);
        checks++; if (m_data !== 8'h66 || fifo_count !== 5'd1) begin failures++; $display("FAIL fpp_count1 got=%h/%0d exp=66/1", m_data, fifo_count); end
        step(1'b0, 11'd0, 1'b1, 1'b0);
    endtask

    task automatic test_parity();
        logic exp;
`ifdef UART_RX_PARITY_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        step(1'b1, mk(8'h07, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
        checks++; if (m_data !== 8'h07 || m_perr !== exp) begin failures++; $display("FAIL parity_07 got=%h/%b exp=07/%b", m_data, m_perr, exp); end
        step(1'b1, mk(8'h07, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0);
        checks++; if (m_data !== 8'h07 || m_perr !== 1'b0) begin failures++; $display("FAIL parity_07_ok got=%h/%b exp=07/0", m_data, m_perr); end
        step(1'b0, 11'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [10:0] f;
        logic        fv;
        logic        rdy;
        logic        clr;
        for (int i = 0; i < 400; i++) begin
            f   = mk(8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) != 0));
            fv  = ($urandom_range(0, 9) < 6);
            rdy = 1'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            step(fv, f, rdy, clr);
            checks++; if (m_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, m_valid, (q.size() != 0)); end
            checks++; if (fifo_count !== 5'(q.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, fifo_count, q.size()); end
            if (q.size() != 0) begin
                checks++; if ({m_perr, m_data} !== q[0]) begin failures++; $display("FAIL rand_head[%0d] got=%h exp=%h", i, {m_perr, m_data}, q[0]); end
            end
            checks++; if ({framing_err, overrun_err} !== {m_fe, m_ov}) begin failures++; $display("FAIL rand_flags[%0d] got=%b%b exp=%b%b", i, framing_err, overrun_err, m_fe, m_ov); end
            checks++; if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL rand_errcnt[%0d] got=%0d exp=%0d", i, err_cnt, m_err); end
        end
        while (q.size() != 0) step(1'b0, 11'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, good(8'hC0 + 8'(i)), 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd3) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=3", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin failures++; $display("FAIL rmid_async got=%b/%0d exp=0/0", m_valid, fifo_count); end
        checks++; if (m_data !== 8'h00 || m_perr !== 1'b0) begin failures++; $display("FAIL rmid_data got=%h/%b exp=00/0", m_data, m_perr); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rmid_errcnt got=%0d exp=0", err_cnt); end
        frame_valid = 1'b1;
        frame_in    = good(8'h99);
        @(posedge baud_clk);
        @(negedge baud_clk);
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rmid_no_accept got=%0d exp=0", fifo_count); end
        frame_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        step(1'b1, good(8'h5A), 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd1 || m_data !== 8'h5A) begin failures++; $display("FAIL rmid_recover got=%0d/%h exp=1/5a", fifo_count, m_data); end
        step(1'b0, 11'd0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) step(1'b1, mk(8'($urandom), 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_errcnt got=%0d exp=255", err_cnt); end
        checks++; if (framing_err !== 1'b1 || fifo_count !== 5'd0) begin failures++; $display("FAIL sat_state got=%b/%0d exp=1/0", framing_err, fifo_count); end
        step(1'b0, 11'd0, 1'b0, 1'b1);
        checks++; if (err_cnt !== 8'd255 || framing_err !== 1'b0) begin failures++; $display("FAIL sat_clr got=%0d/%b exp=255/0", err_cnt, framing_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_framing();
        test_overrun();
        test_full_push_pop();
        test_parity();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, receive FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 baud_clk  input  1  sole clock; all state on rising edge. One clock; reset is asynchronous and active-high.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 frame_valid  input  1  one-cycle pulse from the deserializer; frame_in is valid in that cycle.
REQ-006 frame_in  input  11  serial frame, LSB-first: [0] start, [8:1] data, [9] parity, [10] stop.
REQ-007 m_data  output  8  head-of-FIFO data byte (show-ahead).
REQ-008 m_perr  output  1  parity-error tag stored with the head entry.
REQ-009 m_valid  output  1  FIFO non-empty.
REQ-010 m_ready  input  1  consumer accepts the head entry when m_valid&&m_ready.
REQ-011 fifo_count  output  5  current occupancy, 0..FIFO_DEPTH.
REQ-012 framing_err  output  1  sticky: a frame was dropped for a bad start or stop bit.
REQ-013 overrun_err  output  1  sticky: a good frame was dropped because the FIFO was full.
REQ-014 clr_err  input  1  one-cycle pulse; clears both sticky flags.
REQ-015 err_cnt  output  8  saturating count of dropped frames (framing + overrun).

Function
REQ-016 On frame_valid, a framing fault SHALL be frame_in[0]!=0 or frame_in[10]!=1.
REQ-017 A framing fault SHALL drop the frame, set framing_err and increment err_cnt; the FIFO SHALL be unchanged.
REQ-018 Without a framing fault, the frame SHALL be written to the FIFO as {perr, frame_in[8:1]} if accepted.
REQ-019 Accept rule: accept when fifo_count<FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-020 A good frame that is not accepted SHALL set overrun_err, increment err_cnt, and leave FIFO contents intact (newest frame lost).
REQ-021 Latency: a frame accepted in cycle N SHALL be visible to a reader at cycle N+1 (m_valid high, m_data valid when FIFO was empty).
REQ-022 Pop: when m_valid&&m_ready, the read pointer SHALL advance; m_data and m_perr SHALL hold stable while m_valid&&!m_ready.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged; this holds at full and at count=1.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by fifo_count.
REQ-025 err_cnt SHALL saturate at 255 and never wrap.
REQ-026 clr_err SHALL clear framing_err and overrun_err only; err_cnt is not affected.
REQ-027 If a set and clr_err occur in the same cycle, set SHALL win.
REQ-028 frame_valid on consecutive cycles SHALL each be processed independently.

Reset
REQ-029 rst SHALL immediately clear the pointers, fifo_count, framing_err, overrun_err and err_cnt.
REQ-030 During reset, m_valid=0, m_data=8'h00 and m_perr=0.
REQ-031 A reset asserted mid-operation SHALL discard all buffered entries; no frame is accepted while rst=1.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: perr = (^frame_in[9:1]) != PARITY_ODD, stored per entry.
REQ-033 Macro UART_RX_PARITY_EN undefined: the parity bit SHALL be ignored, m_perr SHALL be tied to 0, and PARITY_ODD SHALL have no effect.

Verification
REQ-034 Scenario: frame 11'b1_0_01010101_0 (data 0x55), even parity, m_ready=1 -> m_data=0x55, m_perr=0, m_valid for one cycle at N+1.
REQ-035 Scenario: frame with bit[10]=0 -> no FIFO write, framing_err=1, err_cnt=1; then clr_err -> framing_err=0, err_cnt=1.
REQ-036 Scenario: m_ready=0, five good frames 0x01..0x05 at depth 4 -> fifo_count=4, overrun_err=1; drain yields 0x01..0x04 in order.
REQ-037 Scenario: FIFO full plus frame_valid and pop in the same cycle -> frame accepted, fifo_count stays 4, no overrun.
REQ-038 Scenario: with UART_RX_PARITY_EN, data 0x07 with parity bit 0 -> m_perr=1; without the macro -> m_perr=0.
REQ-039 Scenario: rst pulse with 3 entries buffered -> m_valid=0 and fifo_count=0 immediately; 260 framing faults -> err_cnt=255.
